instruction_encoder_loader: RTL and testbench
=============================================

// Module: instruction_encoder_loader
// PURPOSE
//  Inverse of the CPU instruction decoder. Packs MIPS instruction fields into 32-bit words.
//  Formats: R {opcode,rs,rt,rd,shamt,funct}; I {opcode,rs,rt,immediate}; J {opcode,address}.
//  Streams the packed words into sequential instruction-memory addresses through a
//  registered, back-pressured write port. Used by the testbench/boot path to load programs.
// PARAMETERS
//  ADDR_W     8    width of mem_addr (word address)
//  DEPTH      256  number of words loadable before full; DEPTH <= 2**ADDR_W
//  BASE_ADDR  0    word address of first write after reset/rewind
// PORTS
//  clk        in   1       single clock, all state on posedge
//  reset      in   1       synchronous, active-high
//  rewind     in   1       sync: pointer back to BASE_ADDR, count=0, fmt_err=0, drop pending word
//  in_valid   in   1       field bundle valid
//  in_ready   out  1       bundle accepted when in_valid&&in_ready
//  fmt        in   2       0=R, 1=I, 2=J, 3=illegal
//  opcode     in   6       instr[31:26]
//  rs,rt,rd   in   5 each  instr[25:21],[20:16],[15:11]
//  shamt      in   5       instr[10:6] (R only)
//  funct      in   6       instr[5:0] (R only)
//  immediate  in   16      instr[15:0] (I only)
//  address    in   26      instr[25:0] (J only)
//  mem_valid  out  1       write request valid
//  mem_ready  in   1       memory accepts write when mem_valid&&mem_ready
//  mem_addr   out  ADDR_W  word address of pending write
//  mem_wdata  out  32      packed instruction
//  count      out  ADDR_W+1 words written (memory handshakes completed)
//  full       out  1       count+pending == DEPTH
//  fmt_err    out  1       sticky: an illegal-fmt bundle was accepted
// BEHAVIOUR
//  - Reset values: in_ready=1 (once reset deasserts), mem_valid=0, mem_addr=BASE_ADDR,
//    mem_wdata=0, count=0, full=0, fmt_err=0. Reset overrides all other inputs.
//  - Packing is combinational; the result is captured in a one-entry output register.
//    Latency: accept in cycle N -> mem_valid=1 in cycle N+1.
//  - in_ready = !full && (!mem_valid || mem_ready). in_ready never depends on in_valid.
//  - On accept with legal fmt: the register loads packed word and the next address.
//    mem_valid=1 is held, with addr/wdata stable, until mem_ready.
//  - On accept with fmt=3: no write and pointer unchanged; fmt_err<=1; bundle consumed.
//  - On a memory handshake: count+=1 and mem_addr advances by 1. Back-to-back accept in the
//    same cycle reloads the register, giving one write per cycle sustained.
//  - Unused fields for a format are ignored (e.g. rd/shamt/funct in I; rs/rt in J).
//  - full asserts when words written plus the pending word reach DEPTH; in_ready=0 then.
//    No address wrap; only rewind/reset reopen.
//  - rewind takes priority over simultaneous accept/handshake; that cycle's bundle is NOT consumed.
//  - FSM: IDLE (mem_valid=0), PEND (mem_valid=1), FULL (count==DEPTH, mem_valid=0).
//    IDLE->PEND on legal accept; PEND->IDLE on handshake w/o new accept.
//    PEND->PEND on handshake+accept or stall; ->FULL when last word handshakes.
//    Any->IDLE on rewind.
// STRUCTURE
//  - Shared package: FMT_R/FMT_I/FMT_J/FMT_BAD constants and field bit-position localparams,
//    shared with instruction_decoder.
//  - One sub-module: instr_pack (pure combinational fields+fmt -> 32-bit word, legal flag).
//    The remainder (output register, pointer, counters, FSM) lives in this module.
// TESTING
//  - R add: fmt=0 op=0 rs=1 rt=2 rd=3 shamt=0 funct=0x20
//    -> next cycle mem_wdata=0x00221820, mem_addr=0.
//  - I stream: addi op=8 rs=0 rt=8 imm=5, then lw op=0x23 rs=1 rt=2 imm=4, mem_ready=1
//    -> 0x20080005 @0, 0x8C220004 @1 on consecutive cycles; count=2.
//  - J + backpressure: op=2 address=0x0100000, mem_ready=0 for 3 cycles -> mem_wdata=0x08100000
//    held, in_ready=0; writes once when ready rises.
//  - Illegal fmt=3 between two legal words -> fmt_err=1, addresses 0,1 used, no gap.
//  - Fill: DEPTH=4, 5 bundles offered -> 4 writes, full=1, in_ready=0.
//    rewind -> count=0, mem_addr=BASE_ADDR, full=0.
//  - reset asserted while mem_valid=1 and mem_ready=0 -> next cycle all outputs at reset values,
//    no write issued.

Source files
------------

// File: rtl/instruction_encoder_loader_pkg.sv
// Shared instruction-format codes, field bit positions and loader FSM states.
// Used by the encoder/loader and kept in step with instruction_decoder.
package instruction_encoder_loader_pkg;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_BAD = 2'd3;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int JADDR_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_FULL
  } ld_state_e;

endpackage

// File: rtl/instruction_encoder_loader_instr_pack.sv
// Purely combinational MIPS field packer: fields + format -> 32-bit word and a legal flag.
// Zero latency, no flow control; fields not used by the selected format are ignored.
module instr_pack
  import instruction_encoder_loader_pkg::*;
(
  input  logic [1:0]  fmt_i,
  input  logic [5:0]  opcode_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] immediate_i,
  input  logic [25:0] address_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  always_comb begin
    word_o  = '0;
    legal_o = 1'b1;
    case (fmt_i)
      FMT_R: begin
        word_o[OPCODE_LSB +: 6] = opcode_i;
        word_o[RS_LSB     +: 5] = rs_i;
        word_o[RT_LSB     +: 5] = rt_i;
        word_o[RD_LSB     +: 5] = rd_i;
        word_o[SHAMT_LSB  +: 5] = shamt_i;
        word_o[FUNCT_LSB  +: 6] = funct_i;
      end
      FMT_I: begin
        word_o[OPCODE_LSB +: 6]  = opcode_i;
        word_o[RS_LSB     +: 5]  = rs_i;
        word_o[RT_LSB     +: 5]  = rt_i;
        word_o[IMM_LSB    +: 16] = immediate_i;
      end
      FMT_J: begin
        word_o[OPCODE_LSB +: 6]  = opcode_i;
        word_o[JADDR_LSB  +: 26] = address_i;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_encoder_loader.sv
// Packs instruction fields and streams them to sequential word addresses; accept->mem_valid is 1 cycle.
// One-entry output register: in_ready drops while the pending word is stalled or the region is full.
module instruction_encoder_loader
  import instruction_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rewind,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       immediate,
  input  logic [25:0]       address,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              fmt_err
);

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  ld_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q;

  logic [31:0] pack_word;
  logic        pack_legal;
  logic        accept;
  logic        load;
  logic        wr_done;
  logic        last_wr;

  instr_pack u_pack (
    .fmt_i       (fmt),
    .opcode_i    (opcode),
    .rs_i        (rs),
    .rt_i        (rt),
    .rd_i        (rd),
    .shamt_i     (shamt),
    .funct_i     (funct),
    .immediate_i (immediate),
    .address_i   (address),
    .word_o      (pack_word),
    .legal_o     (pack_legal)
  );

  assign mem_valid = (state_q == ST_PEND);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign fmt_err   = err_q;
  assign full      = (count_q + {{ADDR_W{1'b0}}, mem_valid}) == DEPTH_C;
  assign in_ready  = !full && (!mem_valid || mem_ready);

  // A rewind cycle discards both handshakes, even if the ports show them asserted.
  assign accept  = in_valid && in_ready && !rewind;
  assign load    = accept && pack_legal;
  assign wr_done = mem_valid && mem_ready && !rewind;
  assign last_wr = wr_done && ((count_q + CNT_ONE) == DEPTH_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_C;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (rewind) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_C;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept && !pack_legal) err_q <= 1'b1;
      if (load) wdata_q <= pack_word;
      if (wr_done) begin
        count_q <= count_q + CNT_ONE;
        // Hold the last address once the region is exhausted rather than wrapping.
        if (!last_wr) addr_q <= addr_q + ADDR_ONE;
      end
      case (state_q)
        ST_IDLE: if (load) state_q <= ST_PEND;
        ST_PEND: begin
          if (last_wr)                state_q <= ST_FULL;
          else if (wr_done && !load)  state_q <= ST_IDLE;
        end
        default: state_q <= ST_FULL;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Directed and randomized bench for instruction_encoder_loader against a transaction-level model.
module tb_instruction_encoder_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;
  localparam int BASE   = 3;

  logic              clk = 1'b0;
  logic              reset, rewind, in_valid, in_ready;
  logic [1:0]        fmt;
  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd, shamt;
  logic [15:0]       immediate;
  logic [25:0]       address;
  logic              mem_valid, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full, fmt_err;

  int checks = 0;
  int errors = 0;

  // Model: words completed, whether a word is waiting, its value, sticky error.
  int          m_count;
  bit          m_pend;
  logic [31:0] m_word;
  bit          m_err;

  always #5 clk = ~clk;

  instruction_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .rewind(rewind), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immediate(immediate), .address(address), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .full(full), .fmt_err(fmt_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_pack(input int unsigned f, input int unsigned op,
      input int unsigned s, input int unsigned t, input int unsigned d, input int unsigned sh,
      input int unsigned fn, input int unsigned imm, input int unsigned ja);
    longint unsigned w;
    w = 0;
    if (f == 0)      w = op * 64'd67108864 + s * 2097152 + t * 65536 + d * 2048 + sh * 64 + fn;
    else if (f == 1) w = op * 64'd67108864 + s * 2097152 + t * 65536 + imm;
    else if (f == 2) w = op * 64'd67108864 + ja;
    return 32'(w);
  endfunction

  task automatic drive(input int f, input int op, input int s, input int t, input int d,
      input int sh, input int fn, input int imm, input int ja);
    fmt = 2'(f); opcode = 6'(op); rs = 5'(s); rt = 5'(t); rd = 5'(d);
    shamt = 5'(sh); funct = 6'(fn); immediate = 16'(imm); address = 26'(ja);
  endtask

  task automatic rand_bundle();
    drive($urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom);
  endtask

  // Check outputs mid-cycle against the model, then advance the model over the clock edge.
  task automatic cycle();
    bit m_full, m_rdy, acc, hs;
    @(negedge clk);
    m_full = (m_count + int'(m_pend)) == DEPTH;
    m_rdy  = !m_full && (!m_pend || mem_ready);
    if (!reset) begin
      check("in_ready", in_ready, m_rdy);
      check("mem_valid", mem_valid, m_pend);
      check("count", count, m_count);
      check("full", full, m_full);
      check("fmt_err", fmt_err, m_err);
      if (m_count < DEPTH) check("mem_addr", mem_addr, BASE + m_count);
      if (m_pend) check("mem_wdata", mem_wdata, m_word);
    end
    @(posedge clk);
    if (reset) begin
      m_count = 0; m_pend = 0; m_err = 0; m_word = '0;
    end else if (rewind) begin
      m_count = 0; m_pend = 0; m_err = 0;
    end else begin
      hs  = m_pend && mem_ready;
      acc = in_valid && m_rdy;
      if (hs) begin
        m_count++;
        m_pend = 0;
      end
      if (acc) begin
        if (fmt == 2'd3) m_err = 1;
        else begin
          m_pend = 1;
          m_word = ref_pack(fmt, opcode, rs, rt, rd, shamt, funct, immediate, address);
        end
      end
    end
    #1;
  endtask

  task automatic do_rewind();
    in_valid = 0; rewind = 1; cycle(); rewind = 0;
  endtask

  initial begin
    reset = 1; rewind = 0; in_valid = 0; mem_ready = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_count = 0; m_pend = 0; m_err = 0; m_word = '0;
    cycle(); cycle();
    reset = 0;
    cycle();
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_addr", mem_addr, BASE);
    check("rst_in_ready", in_ready, 1'b1);

    // R-type add
    drive(0, 0, 1, 2, 3, 0, 32, 0, 0); in_valid = 1; mem_ready = 0;
    cycle();
    in_valid = 0;
    check("r_add_word", mem_wdata, 32'h00221820);
    check("r_add_addr", mem_addr, BASE);
    mem_ready = 1; cycle();
    do_rewind();

    // I-type stream with a handshake in every cycle
    drive(1, 8, 0, 8, 31, 31, 63, 5, 0); in_valid = 1; mem_ready = 1;
    cycle();
    check("i_addi_word", mem_wdata, 32'h20080005);
    check("i_addi_addr", mem_addr, BASE);
    drive(1, 35, 1, 2, 0, 0, 0, 4, 0);
    cycle();
    check("i_lw_word", mem_wdata, 32'h8C220004);
    check("i_lw_addr", mem_addr, BASE + 1);
    in_valid = 0;
    cycle();
    check("i_count", count, 2);
    do_rewind();

    // J-type held under backpressure
    drive(2, 2, 7, 7, 0, 0, 0, 0, 26'h0100000); in_valid = 1; mem_ready = 0;
    cycle();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("j_hold_word", mem_wdata, 32'h08100000);
      check("j_hold_rdy", in_ready, 1'b0);
    end
    mem_ready = 1; cycle();
    check("j_count", count, 1);
    check("j_valid_drop", mem_valid, 1'b0);
    do_rewind();

    // Illegal format between two legal words
    mem_ready = 1; in_valid = 1;
    drive(0, 0, 4, 5, 6, 1, 2, 0, 0); cycle();
    drive(3, 1, 1, 1, 1, 1, 1, 1, 1); cycle();
    drive(1, 9, 3, 4, 0, 0, 0, 77, 0); cycle();
    check("bad_addr_nogap", mem_addr, BASE + 1);
    in_valid = 0; cycle();
    check("bad_err", fmt_err, 1'b1);
    check("bad_count", count, 2);
    do_rewind();
    check("rewind_err_clr", fmt_err, 1'b0);

    // Fill the region
    mem_ready = 1; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      drive($urandom_range(0, 2), $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom);
      cycle();
    end
    in_valid = 1; cycle(); cycle();
    check("fill_count", count, DEPTH);
    check("fill_full", full, 1'b1);
    check("fill_rdy", in_ready, 1'b0);
    do_rewind();
    check("rew_count", count, 0);
    check("rew_addr", mem_addr, BASE);
    check("rew_full", full, 1'b0);

    // Reset while a word is stalled
    drive(2, 3, 0, 0, 0, 0, 0, 0, 26'h3FFFFFF); in_valid = 1; mem_ready = 0;
    cycle();
    in_valid = 0; reset = 1; cycle(); reset = 0;
    #1;
    check("rst2_valid", mem_valid, 1'b0);
    check("rst2_wdata", mem_wdata, 32'h0);
    check("rst2_count", count, 0);
    check("rst2_addr", mem_addr, BASE);
    cycle();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rand_bundle();
      in_valid  = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      rewind    = ($urandom_range(0, 39) == 0);
      cycle();
    end
    rewind = 0; in_valid = 0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
